mac_column_sequencer: RTL and testbench

- Sequences one in-memory MAC operation over a column range of the 16x16 RRAM array.
- Per column step: fetches one input word from the input buffer, drives it onto the word lines, precharges, evaluates, and routes the column through MUX1/MUX2 to ADC1/ADC2. It then captures the conversion and pushes the result into the output buffer.
- Sits between the instruction decoder, which issues start plus operands, and the array periphery: WL/BL/SL enables, PRE, S_MUX, SEL_MUX_TO_ADC and CLK_EN_ADC.

---
 rtl/mac_column_sequencer_pkg.sv | 25 ++
 rtl/mac_adc_route.sv | 46 ++++
 rtl/mac_column_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mac_column_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_column_sequencer_pkg.sv
// Shared definitions for the MAC column sequencer: FSM encodings, array constants
// and the instruction decoder opcodes that launch a sequencer run.
package mac_column_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_PRECH = 3'd2;
  localparam state_t ST_EVAL  = 3'd3;
  localparam state_t ST_CONV  = 3'd4;
  localparam state_t ST_WRITE = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

  // Columns at or above MUX_HALF are served by MUX2/ADC2.
  localparam int          MUX_HALF  = 8;
  localparam logic [15:0] WL_GROUND = 16'hFFFF;

  // Decoder opcodes; OP_MAC is the one that pulses start.
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_LOAD_IF = 4'h1;
  localparam logic [3:0] OP_MAC     = 4'h2;
  localparam logic [3:0] OP_READ_OB = 4'h3;

endpackage

// File: rtl/mac_adc_route.sv
// Column-to-periphery routing: picks MUX1/ADC1 for the lower half of the array,
// MUX2/ADC2 for the upper half, and returns the matching conversion result.
module mac_adc_route
  import mac_column_sequencer_pkg::*;
#(
  parameter int ARRAY_DEPTH = 4,
  parameter int ADC_BITS    = 8
) (
  input  logic [ARRAY_DEPTH-1:0] col,
  input  logic                   adc_en,
  input  logic [ADC_BITS-1:0]    adc1_data,
  input  logic [ADC_BITS-1:0]    adc2_data,
  output logic [2:0]             s_mux1,
  output logic [2:0]             s_mux2,
  output logic                   sel_mux1_to_adc,
  output logic                   sel_mux2_to_adc,
  output logic                   clk_en_adc1,
  output logic                   clk_en_adc2,
  output logic [ADC_BITS-1:0]    adc_data
);

  logic upper_s;

  // Decode the half of the array the column lives in and drive only that path.
  always_comb begin
    upper_s = (col >= ARRAY_DEPTH'(MUX_HALF));
    if (upper_s) begin
      s_mux1          = 3'd0;
      s_mux2          = col[2:0];
      sel_mux1_to_adc = 1'b0;
      sel_mux2_to_adc = 1'b1;
      clk_en_adc1     = 1'b0;
      clk_en_adc2     = adc_en;
      adc_data        = adc2_data;
    end else begin
      s_mux1          = col[2:0];
      s_mux2          = 3'd0;
      sel_mux1_to_adc = 1'b1;
      sel_mux2_to_adc = 1'b0;
      clk_en_adc1     = adc_en;
      clk_en_adc2     = 1'b0;
      adc_data        = adc1_data;
    end
  end

endmodule

// File: rtl/mac_column_sequencer.sv
// MAC column sequencer: walks a column range of the RRAM array, doing
// fetch / precharge / evaluate / convert / write for each column.
module mac_column_sequencer
  import mac_column_sequencer_pkg::*;
#(
  parameter int ARRAY_SIZE  = 16,
  parameter int ARRAY_DEPTH = 4,
  parameter int IF_ADDR_W   = 5,
  parameter int ADC_BITS    = 8,
  parameter int PRE_CYCLES  = 2,
  parameter int EVAL_CYCLES = 1,
  parameter int ADC_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ARRAY_DEPTH-1:0]          col_start,
  input  logic [ARRAY_DEPTH-1:0]          col_end,
  input  logic [IF_ADDR_W-1:0]            if_start_addr,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            ib_rd_en,
  output logic [IF_ADDR_W-1:0]            ib_addr,
  input  logic [ARRAY_SIZE-1:0]           ib_data,
  output logic [ARRAY_SIZE-1:0]           wl_pattern,
  output logic                            pre,
  output logic                            enable_wl,
  output logic                            enable_bl,
  output logic                            enable_sl,
  output logic [2:0]                      s_mux1,
  output logic [2:0]                      s_mux2,
  output logic                            sel_mux1_to_adc,
  output logic                            sel_mux2_to_adc,
  output logic                            clk_en_adc1,
  output logic                            clk_en_adc2,
  input  logic [ADC_BITS-1:0]             adc1_data,
  input  logic [ADC_BITS-1:0]             adc2_data,
  input  logic                            adc_valid,
  output logic                            ob_wr_en,
  output logic [ARRAY_DEPTH+ADC_BITS-1:0] ob_data,
  input  logic                            ob_full
);

  localparam int CNT_MAX = (ADC_TIMEOUT > PRE_CYCLES)
                         ? ((ADC_TIMEOUT > EVAL_CYCLES) ? ADC_TIMEOUT : EVAL_CYCLES)
                         : ((PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [ARRAY_SIZE-1:0] WL_GND = {ARRAY_SIZE{WL_GROUND[0]}};

  state_t                 state_r;
  logic [ARRAY_DEPTH-1:0] col_r;
  logic [ARRAY_DEPTH-1:0] col_end_r;
  logic [IF_ADDR_W-1:0]   addr_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [ADC_BITS-1:0]    result_r;

  logic [ARRAY_DEPTH-1:0] route_col_s;
  logic                   route_adc_en_s;
  logic [2:0]             s_mux1_s;
  logic [2:0]             s_mux2_s;
  logic                   sel1_s;
  logic                   sel2_s;
  logic                   clk_en1_s;
  logic                   clk_en2_s;
  logic [ADC_BITS-1:0]    adc_data_s;

  // In IDLE the route looks at the incoming first column so selects are valid from the first FETCH.
  always_comb begin
    route_adc_en_s = (state_r == ST_EVAL);
    if (state_r == ST_IDLE) begin
      route_col_s = col_start;
    end else begin
      route_col_s = col_r;
    end
  end

  mac_adc_route #(
    .ARRAY_DEPTH (ARRAY_DEPTH),
    .ADC_BITS    (ADC_BITS)
  ) u_route (
    .col             (route_col_s),
    .adc_en          (route_adc_en_s),
    .adc1_data       (adc1_data),
    .adc2_data       (adc2_data),
    .s_mux1          (s_mux1_s),
    .s_mux2          (s_mux2_s),
    .sel_mux1_to_adc (sel1_s),
    .sel_mux2_to_adc (sel2_s),
    .clk_en_adc1     (clk_en1_s),
    .clk_en_adc2     (clk_en2_s),
    .adc_data        (adc_data_s)
  );

  // Sequencer FSM; every periphery output is a flop set on entry to the state that owns it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= ST_IDLE;
      col_r           <= '0;
      col_end_r       <= '0;
      addr_r          <= '0;
      cnt_r           <= '0;
      result_r        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      ib_rd_en        <= 1'b0;
      ib_addr         <= '0;
      wl_pattern      <= WL_GND;
      pre             <= 1'b0;
      enable_wl       <= 1'b0;
      enable_bl       <= 1'b0;
      enable_sl       <= 1'b0;
      s_mux1          <= 3'd0;
      s_mux2          <= 3'd0;
      sel_mux1_to_adc <= 1'b0;
      sel_mux2_to_adc <= 1'b0;
      clk_en_adc1     <= 1'b0;
      clk_en_adc2     <= 1'b0;
      ob_wr_en        <= 1'b0;
      ob_data         <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      ob_wr_en  <= 1'b0;
      enable_sl <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (col_end >= col_start)) begin
            state_r         <= ST_FETCH;
            col_r           <= col_start;
            col_end_r       <= col_end;
            addr_r          <= if_start_addr;
            cnt_r           <= '0;
            busy            <= 1'b1;
            ib_rd_en        <= 1'b1;
            ib_addr         <= if_start_addr;
            s_mux1          <= s_mux1_s;
            s_mux2          <= s_mux2_s;
            sel_mux1_to_adc <= sel1_s;
            sel_mux2_to_adc <= sel2_s;
          end else if (start) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else begin
            cnt_r <= '0;
          end
        end
        ST_FETCH: begin
          ib_rd_en <= 1'b0;
          if (cnt_r == '0) begin
            cnt_r <= CNT_W'(1);
          end else begin
            cnt_r           <= '0;
            wl_pattern      <= ib_data;
            pre             <= 1'b1;
            s_mux1          <= s_mux1_s;
            s_mux2          <= s_mux2_s;
            sel_mux1_to_adc <= sel1_s;
            sel_mux2_to_adc <= sel2_s;
            state_r         <= ST_PRECH;
          end
        end
        ST_PRECH: begin
          if (cnt_r == CNT_W'(PRE_CYCLES - 1)) begin
            cnt_r     <= '0;
            pre       <= 1'b0;
            enable_wl <= 1'b1;
            enable_bl <= 1'b1;
            state_r   <= ST_EVAL;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_EVAL: begin
          if (cnt_r == CNT_W'(EVAL_CYCLES - 1)) begin
            cnt_r       <= '0;
            clk_en_adc1 <= clk_en1_s;
            clk_en_adc2 <= clk_en2_s;
            state_r     <= ST_CONV;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_CONV: begin
          if (adc_valid) begin
            result_r    <= adc_data_s;
            clk_en_adc1 <= 1'b0;
            clk_en_adc2 <= 1'b0;
            enable_wl   <= 1'b0;
            enable_bl   <= 1'b0;
            wl_pattern  <= WL_GND;
            cnt_r       <= '0;
            state_r     <= ST_WRITE;
          end else if (cnt_r == CNT_W'(ADC_TIMEOUT - 1)) begin
            // Abort: park the array, keep whatever already reached the output buffer.
            state_r         <= ST_IDLE;
            cnt_r           <= '0;
            busy            <= 1'b0;
            done            <= 1'b1;
            err             <= 1'b1;
            wl_pattern      <= WL_GND;
            enable_wl       <= 1'b0;
            enable_bl       <= 1'b0;
            s_mux1          <= 3'd0;
            s_mux2          <= 3'd0;
            sel_mux1_to_adc <= 1'b0;
            sel_mux2_to_adc <= 1'b0;
            clk_en_adc1     <= 1'b0;
            clk_en_adc2     <= 1'b0;
            ib_addr         <= '0;
            ob_data         <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (!ob_full) begin
            ob_wr_en <= 1'b1;
            ob_data  <= {col_r, result_r};
            if (col_r == col_end_r) begin
              state_r         <= ST_DONE;
              busy            <= 1'b0;
              done            <= 1'b1;
              s_mux1          <= 3'd0;
              s_mux2          <= 3'd0;
              sel_mux1_to_adc <= 1'b0;
              sel_mux2_to_adc <= 1'b0;
            end else begin
              state_r  <= ST_FETCH;
              col_r    <= col_r + ARRAY_DEPTH'(1);
              addr_r   <= addr_r + IF_ADDR_W'(1);
              ib_rd_en <= 1'b1;
              ib_addr  <= addr_r + IF_ADDR_W'(1);
              cnt_r    <= '0;
            end
          end else begin
            cnt_r <= '0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r         <= ST_IDLE;
          busy            <= 1'b0;
          ib_rd_en        <= 1'b0;
          wl_pattern      <= WL_GND;
          pre             <= 1'b0;
          enable_wl       <= 1'b0;
          enable_bl       <= 1'b0;
          sel_mux1_to_adc <= 1'b0;
          sel_mux2_to_adc <= 1'b0;
          clk_en_adc1     <= 1'b0;
          clk_en_adc2     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_column_sequencer.sv
// Self-checking bench for mac_column_sequencer: scoreboarded output-buffer writes,
// an input-buffer and ADC responder, and per-scenario tasks.
module tb_mac_column_sequencer;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0]  col_start = 4'd0, col_end = 4'd0;
  logic [4:0]  if_start_addr = 5'd0;
  logic        busy, done, err, ib_rd_en;
  logic [4:0]  ib_addr;
  logic [15:0] ib_data = 16'h0000, wl_pattern;
  logic        pre, enable_wl, enable_bl, enable_sl;
  logic [2:0]  s_mux1, s_mux2;
  logic        sel_mux1_to_adc, sel_mux2_to_adc, clk_en_adc1, clk_en_adc2;
  logic [7:0]  adc1_data = 8'h00, adc2_data = 8'h00;
  logic        adc_valid = 1'b0, ob_wr_en, ob_full = 1'b0;
  logic [11:0] ob_data;

  int n_checks = 0, n_fail = 0;
  logic [11:0] exp_q[$];
  logic [4:0]  addr_log[$];
  logic [15:0] wl_log[$];
  logic [7:0]  mux_log[$];
  logic [1:0]  en_log[$];
  logic [15:0] ib_mem[32];
  logic [7:0]  adc1_tbl[16], adc2_tbl[16];
  int cur_col = 0, adc_lat = 3, adc_wait = 0, full_left = 0, stall_col = -1;
  int done_cnt = 0, act_cnt = 0;
  bit adc_withhold = 1'b0;
  logic pre_d = 1'b0, en_d = 1'b0;

  wire [12:0] ctl_w = {busy, done, err, ib_rd_en, pre, enable_wl, enable_bl, enable_sl,
                       sel_mux1_to_adc, sel_mux2_to_adc, clk_en_adc1, clk_en_adc2, ob_wr_en};
  wire [22:0] dat_w = {ib_addr, s_mux1, s_mux2, ob_data};

  mac_column_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .col_start(col_start), .col_end(col_end),
    .if_start_addr(if_start_addr), .busy(busy), .done(done), .err(err),
    .ib_rd_en(ib_rd_en), .ib_addr(ib_addr), .ib_data(ib_data), .wl_pattern(wl_pattern),
    .pre(pre), .enable_wl(enable_wl), .enable_bl(enable_bl), .enable_sl(enable_sl),
    .s_mux1(s_mux1), .s_mux2(s_mux2), .sel_mux1_to_adc(sel_mux1_to_adc),
    .sel_mux2_to_adc(sel_mux2_to_adc), .clk_en_adc1(clk_en_adc1), .clk_en_adc2(clk_en_adc2),
    .adc1_data(adc1_data), .adc2_data(adc2_data), .adc_valid(adc_valid),
    .ob_wr_en(ob_wr_en), .ob_data(ob_data), .ob_full(ob_full)
  );

  always #5 clk = ~clk;

  // Monitor first (sees values settled at the last posedge), then the memory/ADC/backpressure responders.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ob_wr_en) begin
          n_checks++;
          if (ob_full) begin
            n_fail++;
            $display("FAIL ob_wr_while_full: ob_wr_en=1 with ob_full=1, required ob_wr_en=0");
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ob_unexpected_write: got %h, required no write", ob_data);
          end else if (ob_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL ob_data: got %h, required %h", ob_data, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            void'(exp_q.pop_front());
          end
        end
        n_checks++;
        if (pre && enable_wl) begin
          n_fail++;
          $display("FAIL pre_wl_overlap: pre=1 enable_wl=1, required not both");
        end
        if (busy) begin
          n_checks++;
          if ((sel_mux1_to_adc ^ sel_mux2_to_adc) !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_onehot: sel1=%b sel2=%b, required exactly one", sel_mux1_to_adc, sel_mux2_to_adc);
          end
        end
        if (ib_rd_en) begin
          addr_log.push_back(ib_addr);
          ib_data = ib_mem[ib_addr];
        end
        if (pre && !pre_d) begin
          wl_log.push_back(wl_pattern);
          mux_log.push_back({sel_mux2_to_adc, sel_mux1_to_adc, s_mux2, s_mux1});
        end
        if ((clk_en_adc1 || clk_en_adc2) && !en_d) en_log.push_back({clk_en_adc2, clk_en_adc1});
        if (done) done_cnt++;
        if (pre || enable_wl || enable_bl || enable_sl || ib_rd_en) act_cnt++;
        pre_d = pre;
        en_d  = clk_en_adc1 || clk_en_adc2;
        adc_valid = 1'b0;
        if (full_left > 0) begin
          full_left--;
          ob_full = (full_left > 0);
        end
        if ((clk_en_adc1 || clk_en_adc2) && !adc_withhold) begin
          adc_wait++;
          if (adc_wait == adc_lat) begin
            adc1_data = adc1_tbl[cur_col[3:0]];
            adc2_data = adc2_tbl[cur_col[3:0]];
            adc_valid = 1'b1;
            adc_wait  = 0;
            if (cur_col == stall_col) full_left = 6;
            cur_col++;
          end
        end else begin
          adc_wait = 0;
        end
      end
    end
  end

  task automatic clear_logs();
    addr_log.delete(); wl_log.delete(); mux_log.delete(); en_log.delete();
    adc_wait = 0;
  endtask

  task automatic expect_cols(input int cs, input int ce);
    for (int c = cs; c <= ce; c++) exp_q.push_back({4'(c), (c < 8) ? adc1_tbl[c] : adc2_tbl[c]});
  endtask

  task automatic do_start(input logic [3:0] cs, input logic [3:0] ce, input logic [4:0] ia);
    @(negedge clk);
    col_start = cs; col_end = ce; if_start_addr = ia; start = 1'b1;
    cur_col = int'(cs);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks += 3;
    if (ctl_w !== 13'd0) begin n_fail++; $display("FAIL reset_ctl: got %b, required 0", ctl_w); end
    if (dat_w !== 23'd0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", dat_w); end
    if (wl_pattern !== 16'hFFFF) begin n_fail++; $display("FAIL reset_wl: got %h, required ffff", wl_pattern); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_column();
    int lat;
    clear_logs(); adc_lat = 3;
    expect_cols(3, 3);
    do_start(4'd3, 4'd3, 5'd5);
    wait_done(40, lat);
    n_checks += 2;
    if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, required 0", err); end
    if (lat != 9) begin n_fail++; $display("FAIL single_latency: got %0d, required 9", lat); end
    check_drained("single");
    n_checks += 3;
    if (addr_log.size() != 1 || addr_log[0] !== 5'd5) begin n_fail++; $display("FAIL single_ib_addr: got %p, required '{5}", addr_log); end
    if (wl_log.size() != 1 || wl_log[0] !== 16'hA5A5) begin n_fail++; $display("FAIL single_wl: got %p, required '{a5a5}", wl_log); end
    if (mux_log.size() != 1 || mux_log[0] !== {1'b0, 1'b1, 3'd0, 3'd3}) begin n_fail++; $display("FAIL single_mux: got %p, required '{{sel1,s_mux1=3}}", mux_log); end
  endtask

  task automatic test_mux_boundary();
    int lat;
    logic [3:0] c;
    clear_logs(); adc_lat = 2;
    expect_cols(6, 9);
    do_start(4'd6, 4'd9, 5'd0);
    wait_done(100, lat);
    n_checks += 3;
    if (err !== 1'b0) begin n_fail++; $display("FAIL mux_err: got %b, required 0", err); end
    if (lat != 32) begin n_fail++; $display("FAIL mux_latency: got %0d, required 32", lat); end
    if (mux_log.size() != 4 || en_log.size() != 4 || addr_log.size() != 4 || wl_log.size() != 4) begin
      n_fail++; $display("FAIL mux_log_sizes: got %0d/%0d/%0d/%0d, required 4 each", mux_log.size(), en_log.size(), addr_log.size(), wl_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        c = 4'(6 + i);
        n_checks += 4;
        if (mux_log[i] !== ((c < 4'd8) ? {1'b0, 1'b1, 3'd0, c[2:0]} : {1'b1, 1'b0, c[2:0], 3'd0})) begin
          n_fail++; $display("FAIL mux_select col %0d: got %b, required other routing", c, mux_log[i]);
        end
        if (en_log[i] !== ((c < 4'd8) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL mux_clk_en col %0d: got %b", c, en_log[i]); end
        if (addr_log[i] !== 5'(i)) begin n_fail++; $display("FAIL mux_ib_addr: got %0d, required %0d", addr_log[i], i); end
        if (wl_log[i] !== ib_mem[i]) begin n_fail++; $display("FAIL mux_wl: got %h, required %h", wl_log[i], ib_mem[i]); end
      end
    end
    check_drained("mux");
  endtask

  task automatic test_backpressure();
    int lat;
    clear_logs(); adc_lat = 2; stall_col = 2;
    expect_cols(1, 3);
    do_start(4'd1, 4'd3, 5'd8);
    wait_done(120, lat);
    n_checks++;
    if (lat != 29) begin n_fail++; $display("FAIL bp_latency: got %0d, required 29 (24 + 5 stall)", lat); end
    check_drained("bp");
    stall_col = -1;
  endtask

  task automatic test_errors();
    int lat, act0, d0;
    act0 = act_cnt;
    do_start(4'd9, 4'd4, 5'd0);
    n_checks += 2;
    if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL bad_range_pulse: done=%b err=%b, required 1 1", done, err); end
    @(negedge clk);
    if (done !== 1'b0) begin n_fail++; $display("FAIL bad_range_width: done=%b, required 0", done); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (act_cnt != act0 || busy !== 1'b0) begin n_fail++; $display("FAIL bad_range_activity: %0d active cycles busy=%b, required 0 0", act_cnt - act0, busy); end
    clear_logs(); adc_withhold = 1'b1;
    do_start(4'd4, 4'd4, 5'd2);
    wait_done(80, lat);
    n_checks += 4;
    if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b, required 1", err); end
    if (lat != 20) begin n_fail++; $display("FAIL timeout_latency: got %0d, required 20", lat); end
    if (ctl_w !== 13'b0110000000000) begin n_fail++; $display("FAIL timeout_ctl: got %b, required 0110000000000", ctl_w); end
    if (wl_pattern !== 16'hFFFF || s_mux1 !== 3'd0 || s_mux2 !== 3'd0) begin
      n_fail++; $display("FAIL timeout_drives: wl=%h s_mux1=%0d s_mux2=%0d, required ffff 0 0", wl_pattern, s_mux1, s_mux2);
    end
    adc_withhold = 1'b0;
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL timeout_extra_done: got %0d, required 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_conv();
    int k, d0, lat;
    clear_logs(); adc_lat = 8;
    do_start(4'd0, 4'd2, 5'd0);
    k = 0;
    while (!(clk_en_adc1 || clk_en_adc2) && k < 40) begin @(negedge clk); k++; end
    n_checks++;
    if (!(clk_en_adc1 || clk_en_adc2)) begin n_fail++; $display("FAIL rst_reach_conv: no clk_en in %0d cycles, required CONV", k); end
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    n_checks += 3;
    if (ctl_w !== 13'd0) begin n_fail++; $display("FAIL rst_mid_ctl: got %b, required 0", ctl_w); end
    if (dat_w !== 23'd0) begin n_fail++; $display("FAIL rst_mid_data: got %h, required 0", dat_w); end
    if (wl_pattern !== 16'hFFFF) begin n_fail++; $display("FAIL rst_mid_wl: got %h, required ffff", wl_pattern); end
    @(negedge clk);
    rst = 1'b1;
    adc_wait = 0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: %0d dones busy=%b, required 0 0", done_cnt - d0, busy); end
    clear_logs(); adc_lat = 3;
    expect_cols(5, 5);
    do_start(4'd5, 4'd5, 5'd7);
    wait_done(40, lat);
    n_checks++;
    if (err !== 1'b0 || lat != 9) begin n_fail++; $display("FAIL rst_rerun: err=%b lat=%0d, required 0 9", err, lat); end
    check_drained("rst_rerun");
  endtask

  task automatic test_wrap_busy();
    int lat, d0;
    clear_logs(); adc_lat = 2;
    d0 = done_cnt;
    expect_cols(0, 1);
    do_start(4'd0, 4'd1, 5'd31);
    repeat (3) @(negedge clk);
    col_start = 4'd5; col_end = 4'd5; if_start_addr = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(80, lat);
    check_drained("wrap");
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (addr_log.size() != 2 || addr_log[0] !== 5'd31 || addr_log[1] !== 5'd0) begin
      n_fail++; $display("FAIL wrap_ib_addr: got %p, required '{31,0}", addr_log);
    end
    if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d, required 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_logs(); adc_lat = 1;
    expect_cols(7, 7);
    do_start(4'd7, 4'd7, 5'd3);
    wait_done(40, lat);
    col_start = 4'd10; col_end = 4'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_start: busy=%b, required 0 (start in DONE ignored)", busy); end
    check_drained("b2b_first");
    expect_cols(12, 12);
    do_start(4'd12, 4'd12, 5'd4);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy=%b, required 1", busy); end
    wait_done(40, lat);
    n_checks++;
    if (err !== 1'b0 || lat != 7) begin n_fail++; $display("FAIL b2b_second: err=%b lat=%0d, required 0 7", err, lat); end
    check_drained("b2b_second");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ib_mem[i] = 16'(i * 16'h0F1D + 16'h1234);
    ib_mem[5] = 16'hA5A5;
    for (int c = 0; c < 16; c++) begin
      adc1_tbl[c] = 8'(8'h3F + c);
      adc2_tbl[c] = 8'(8'hC0 + c);
    end
    test_reset();
    test_single_column();
    test_mux_boundary();
    test_backpressure();
    test_errors();
    test_reset_mid_conv();
    test_wrap_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
